// File: rtl/bin2bcd_pipe.sv
// Pipelined signed 11-bit binary to sign-magnitude BCD converter (sign + 4 digits).
// An input capture stage is followed by PIPE_STAGE double-dabble stages.
module bin2bcd_pipe #(
   parameter int PIPE_STAGE = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [10:0] bin,
   input  logic        bin_vld,
   output logic [16:0] bcd,
   output logic        bcd_vld
);

   localparam int NBITS = 11;
   localparam int DW    = 1 + 16 + NBITS;

   // Stage word layout: [DW-1] sign, [DW-2:NBITS] four BCD digits, [NBITS-1:0] magnitude still to shift.

   // Earlier stages take the extra iteration when NBITS does not divide evenly.
   function automatic int iters(input int s);
      return NBITS / PIPE_STAGE + ((s < (NBITS % PIPE_STAGE)) ? 1 : 0);
   endfunction

   function automatic logic [DW-1:0] dabble(input logic [DW-1:0] v_in, input int n);
      logic [DW-1:0] v;
      v = v_in;
      for (int k = 0; k < NBITS; k++) begin
         if (k < n) begin
            for (int d = 0; d < 4; d++) begin
               if (v[NBITS+4*d +: 4] >= 4'd5)
                  v[NBITS+4*d +: 4] = v[NBITS+4*d +: 4] + 4'd3;
            end
            v[DW-2:0] = {v[DW-3:0], 1'b0};
         end
      end
      return v;
   endfunction

   // Valid semantics: bin_vld qualifies bin for one cycle, with no ready and no backpressure.
   // Each valid bit travels with its data word, and a data word loads only when its incoming valid is set.
   logic [NBITS-1:0]  mag;
   logic [DW-1:0]     in_d;
   logic [DW-1:0]     stg_d [PIPE_STAGE+1];
   logic [DW-1:0]     stg_q [PIPE_STAGE+1];
   logic [PIPE_STAGE:0] vld_q;
   logic [NBITS-1:0]  unused_tail;

   // 1024 is still exact as an unsigned 11-bit magnitude, so -1024 needs no special case.
   always_comb begin
      mag  = bin[10] ? (~bin + 11'd1) : bin;
      in_d = {bin[10], 16'h0000, mag};
   end

   always_comb begin
      stg_d[0] = in_d;
      for (int s = 1; s <= PIPE_STAGE; s++) begin
         stg_d[s] = dabble(stg_q[s-1], iters(s-1));
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q <= '0;
         for (int s = 0; s <= PIPE_STAGE; s++) begin
            stg_q[s] <= '0;
         end
      end else begin
         vld_q <= {vld_q[PIPE_STAGE-1:0], bin_vld};
         if (bin_vld)
            stg_q[0] <= stg_d[0];
         for (int s = 1; s <= PIPE_STAGE; s++) begin
            if (vld_q[s-1])
               stg_q[s] <= stg_d[s];
         end
      end
   end

   assign bcd         = stg_q[PIPE_STAGE][DW-1:NBITS];
   assign bcd_vld     = vld_q[PIPE_STAGE];
   assign unused_tail = stg_q[PIPE_STAGE][NBITS-1:0];

endmodule

// File: tb/tb_bin2bcd_pipe.sv
// Directed and sweep bench for bin2bcd_pipe: a scoreboard queue tracks expected
// results and their issue edges, so both values and the 4-clock latency are checked.
module tb_bin2bcd_pipe;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic [10:0] bin;
   logic        bin_vld;
   logic [16:0] bcd;
   logic        bcd_vld;

   always #5 clk = ~clk;

   bin2bcd_pipe #(.PIPE_STAGE(LAT)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .bin     (bin),
      .bin_vld (bin_vld),
      .bcd     (bcd),
      .bcd_vld (bcd_vld)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [16:0] exp_q[$];
   int          iss_q[$];
   logic [16:0] last_exp = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference conversion using integer division, independent of shift-add-3.
   function automatic logic [16:0] model_bcd(input logic [10:0] b);
      int          v;
      int          m;
      logic [16:0] r;
      v = int'($signed(b));
      m = (v < 0) ? -v : v;
      r[16]    = (v < 0);
      r[15:12] = 4'(m / 1000);
      r[11:8]  = 4'((m / 100) % 10);
      r[7:4]   = 4'((m / 10) % 10);
      r[3:0]   = 4'(m % 10);
      return r;
   endfunction

   // Called just after a rising edge; the next rising edge samples the inputs.
   task automatic drive(input logic v, input logic [10:0] b, input logic [16:0] e);
      bin_vld = v;
      bin     = b;
      if (v) begin
         exp_q.push_back(e);
         iss_q.push_back(cyc + 1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 11'($urandom_range(0, 2047)), '0);
   endtask

   task automatic drain();
      int t;
      t = 0;
      bin_vld = 1'b0;
      while (exp_q.size() > 0 && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      check_eq("drain", 32'(exp_q.size()), 32'd0);
      idle(6);
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      logic [16:0] e;
      int          ic;
      if (cyc > 0) begin
         if (!rstn) begin
            last_exp = '0;
            check_eq("rst_vld", 32'(bcd_vld), 32'd0);
            check_eq("rst_bcd", 32'(bcd), 32'd0);
         end else if (bcd_vld) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_pulse", 32'(bcd_vld), 32'd0);
            end else begin
               e  = exp_q.pop_front();
               ic = iss_q.pop_front();
               check_eq("bcd", 32'(bcd), 32'(e));
               check_eq("latency", 32'(cyc - ic), 32'(LAT));
               last_exp = e;
            end
         end else begin
            check_eq("hold", 32'(bcd), 32'(last_exp));
         end
      end
   end

   logic [10:0] dir_bin [9] = '{11'd0, 11'd1023, 11'h7FF, 11'h400, 11'h419,
                                11'd1, 11'd999, 11'h418, 11'd500};
   logic [16:0] dir_exp [9] = '{17'h00000, 17'h01023, 17'h10001, 17'h11024, 17'h10999,
                                17'h00001, 17'h00999, 17'h11000, 17'h00500};

   initial begin
      rstn    = 1'b0;
      bin_vld = 1'b0;
      bin     = '0;
      repeat (10) @(posedge clk);
      #1;
      check_eq("reset_bcd", 32'(bcd), 32'd0);
      check_eq("reset_vld", 32'(bcd_vld), 32'd0);
      rstn = 1'b1;
      idle(3);

      // Isolated single pulses with hand-computed results.
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, dir_bin[i], dir_exp[i]);
         drain();
      end

      // Same vectors back-to-back.
      for (int i = 0; i < 9; i++) drive(1'b1, dir_bin[i], dir_exp[i]);
      drain();

      // Full input sweep, back-to-back.
      for (int i = 0; i < 2048; i++) drive(1'b1, 11'(i), model_bcd(11'(i)));
      drain();

      // Random values with random idle gaps.
      for (int i = 0; i < 200; i++) begin
         logic [10:0] b;
         b = 11'($urandom_range(0, 2047));
         drive(1'b1, b, model_bcd(b));
         idle($urandom_range(0, 15));
      end
      drain();

      // Reset with three conversions in flight: all of them must vanish.
      drive(1'b1, 11'd123, 17'h00123);
      drive(1'b1, 11'h7FF, 17'h10001);
      drive(1'b1, 11'd777, 17'h00777);
      rstn    = 1'b0;
      bin_vld = 1'b0;
      exp_q.delete();
      iss_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check_eq("midrst_bcd", 32'(bcd), 32'd0);
      check_eq("midrst_vld", 32'(bcd_vld), 32'd0);
      rstn = 1'b1;
      idle(12);

      // Recovery after reset.
      drive(1'b1, 11'd42, 17'h00042);
      drain();

      check_eq("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
